shift_unit: RTL
===============

# shift_unit

Iterative barrel-shifter replacement that produces the second ALU operand and the shifter carry-out for data-processing instructions. It implements the ARM shift set: LSL, LSR, ASR, ROR and RRX. It shifts one bit per clock under a start/done handshake. The sequencer presents the result on the ALU `B` input and the carry on `shiftCout`; the ALU uses that carry as C for logical and move operations.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; only 32 is supported.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a shift; sampled only in IDLE.
- `data_in`  in  32  value to shift.
- `shift_num`  in  8  shift amount (register-specified semantics, 0–255).
- `shift_op`  in  3  operation select: 000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101–111 pass-through.
- `c_in`  in  1  current C flag.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; result is valid.
- `shift_out`  out  32  shifted result; to ALU `B`.
- `shift_cout`  out  1  shifter carry; to ALU `shiftCout`.

## Operation
FSM states: IDLE, SHIFT, DONE.

Start and entry into SHIFT or DONE:
- IDLE with `start`=1: latch `data_in` into `shift_out`, `c_in` into `shift_cout`, latch `shift_op`, and load the iteration count N.
- Next state is SHIFT if N>0, otherwise DONE.

Iteration count N:
- LSL/LSR/ASR: N = min(`shift_num`, 32).
- ROR: N = `shift_num`[4:0].
- RRX: N = 1.
- Pass-through: N = 0.

SHIFT step (one per edge; decrement N; go to DONE after the step that takes N to 0):
- LSL: cout←bit31, out←out<<1.
- LSR: cout←bit0, out←out>>1.
- ASR: cout←bit0, out←{bit31,out[31:1]}.
- ROR: cout←bit0, out←{bit0,out[31:1]}.
- RRX: cout←bit0, out←{c_in latched,out[31:1]}.

Final fix-ups, applied on the edge entering DONE:
- LSL/LSR with `shift_num`>32: `shift_out`=0, `shift_cout`=0.
- ROR with `shift_num`≠0 and `shift_num`[4:0]=0: `shift_out`=data, `shift_cout`=data[31].
- Any op with `shift_num`=0 (except RRX): result equals data, `shift_cout`=`c_in`.

DONE: `done`=1 for exactly one cycle, then IDLE. `shift_out`/`shift_cout` hold their values until the next accepted `start`.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `shift_out`=0, `shift_cout`=0, `done`=0, `busy`=0.
- Reset mid-SHIFT aborts the operation; no `done` is produced.
- Latency: with `start` sampled at edge 0, `done` is high during the cycle after edge N, i.e. N+1 cycles after start.
  - Minimum latency is 1 cycle.
  - Maximum latency is 33 cycles (shift by ≥32).
- `busy` rises the cycle after start is accepted and falls the cycle after `done`.
- `start` is ignored in SHIFT and DONE; no queuing. Back-to-back throughput is one op per N+2 cycles.
- `shift_out`/`shift_cout` change during SHIFT and are only meaningful while `done`=1 or afterwards in IDLE.
- Operand inputs are sampled only at the accepting edge; later changes are ignored.

## Test plan
- LSL: `data_in`=0x8000_0001, `shift_num`=1, `c_in`=0 -> `done` 2 cycles after start; `shift_out`=0x0000_0002, `shift_cout`=1.
- LSR:
  - `data_in`=0x8000_0000, `shift_num`=32 -> `shift_out`=0, `shift_cout`=1, latency 33.
  - Same data, `shift_num`=40 -> `shift_out`=0, `shift_cout`=0, latency 33.
- ASR:
  - `data_in`=0x8000_0000, `shift_num`=4 -> 0xF800_0000, `shift_cout`=0, latency 5.
  - `shift_num`=0, `c_in`=1 -> 0x8000_0000, `shift_cout`=1, latency 1.
- ROR and RRX:
  - ROR `data_in`=0x0000_00F1, `shift_num`=4 -> 0x1000_000F, `shift_cout`=0.
  - ROR 0x8000_0000 by 32 -> unchanged, `shift_cout`=1, latency 1.
  - RRX 0x0000_0003, `c_in`=1 -> 0x8000_0001, `shift_cout`=1, latency 2.
- Handshake and reset:
  - Assert `start` with new operands while `busy` -> ignored; the first result is unaffected.
  - Assert `rst_n`=0 during an LSL-by-20 -> next cycle IDLE, all outputs 0, no `done` pulse.

Source files
------------

// File: rtl/shift_unit.sv
// Iterative shifter for the ALU B operand: LSL/LSR/ASR/ROR/RRX, one bit per clock.
// Produces the shifted value and shifter carry under a start/done handshake.
module shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [7:0]       shift_num,
  input  logic [2:0]       shift_op,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shift_out,
  output logic             shift_cout
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {
    OP_LSL = 3'b000,
    OP_LSR = 3'b001,
    OP_ASR = 3'b010,
    OP_ROR = 3'b011,
    OP_RRX = 3'b100
  } op_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [5:0]       cnt;
  logic [5:0]       load_cnt;
  logic             cin_q;
  logic             zero_fix;
  logic [WIDTH-1:0] step_out;
  logic             step_cout;

  always_comb begin
    load_cnt = '0;
    case (shift_op)
      OP_LSL, OP_LSR, OP_ASR: load_cnt = (shift_num > 8'd32) ? 6'd32 : shift_num[5:0];
      OP_ROR:                 load_cnt = {1'b0, shift_num[4:0]};
      OP_RRX:                 load_cnt = 6'd1;
      default:                load_cnt = '0;
    endcase
  end

  always_comb begin
    step_out  = shift_out;
    step_cout = shift_cout;
    case (op_q)
      OP_LSL: begin
        step_cout = shift_out[WIDTH-1];
        step_out  = {shift_out[WIDTH-2:0], 1'b0};
      end
      OP_LSR: begin
        step_cout = shift_out[0];
        step_out  = {1'b0, shift_out[WIDTH-1:1]};
      end
      OP_ASR: begin
        step_cout = shift_out[0];
        step_out  = {shift_out[WIDTH-1], shift_out[WIDTH-1:1]};
      end
      OP_ROR: begin
        step_cout = shift_out[0];
        step_out  = {shift_out[0], shift_out[WIDTH-1:1]};
      end
      OP_RRX: begin
        step_cout = shift_out[0];
        step_out  = {cin_q, shift_out[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = (load_cnt == 6'd0) ? DONE : SHIFT;
      SHIFT:   if (cnt == 6'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-count cases resolve their fix-ups at accept time; LSL/LSR beyond 32
  // run the full 32 steps and clear the result on the final step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_out  <= '0;
      shift_cout <= 1'b0;
      op_q       <= '0;
      cnt        <= '0;
      cin_q      <= 1'b0;
      zero_fix   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          shift_out  <= data_in;
          shift_cout <= (shift_op == OP_ROR && shift_num != 8'd0 && shift_num[4:0] == 5'd0)
                        ? data_in[WIDTH-1] : c_in;
          op_q       <= shift_op;
          cnt        <= load_cnt;
          cin_q      <= c_in;
          zero_fix   <= (shift_op == OP_LSL || shift_op == OP_LSR) && (shift_num > 8'd32);
        end
        SHIFT: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1 && zero_fix) begin
            shift_out  <= '0;
            shift_cout <= 1'b0;
          end else begin
            shift_out  <= step_out;
            shift_cout <= step_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
